// File: rtl/m6809_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the m6809 bus, fed through a small TX FIFO.
// Latency: a DATA write into an empty FIFO with the line idle starts the start bit one cycle later; a frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none toward the core; a write into a full FIFO (with no pop that cycle) is dropped and sets overrun.
module m6809_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic [1:0] a,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       txd,
    output logic       irq
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic          tx_en;
    logic          irq_en;
    logic          overrun;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_d;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_d;
    logic [7:0]    shift;
    logic [7:0]    shift_d;
    logic          txd_d;

    logic wr_data;
    logic wr_status;
    logic wr_ctrl;
    logic full;
    logic empty;
    logic busy;
    logic pop;
    logic push_ok;

    assign wr_data   = sel & ~wr_n & (a == 2'd0);
    assign wr_status = sel & ~wr_n & (a == 2'd1);
    assign wr_ctrl   = sel & ~wr_n & (a == 2'd2);
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign busy      = (state != ST_IDLE);
    assign pop       = (state == ST_IDLE) & tx_en & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = wr_data & (~full | pop);

    // FIFO storage: written on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
            if (wr_data & full & ~pop) begin
                overrun <= 1'b1;
            end else if (wr_status & din[3]) begin
                overrun <= 1'b0;
            end
        end
    end

    // Control register; tx_en comes out of reset enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_en  <= 1'b1;
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            tx_en  <= din[0];
            irq_en <= din[1];
        end
    end

    // Serialiser next state: start bit, eight data bits LSB first, stop bit.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    shift_d   = fifo_mem[rd_ptr];
                end
            end
            ST_START: begin
                if (bit_cnt == CNT_LAST) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // txd is registered from the next state so the pin never glitches.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Serialiser state register; reset abandons any frame and idles the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            txd     <= 1'b1;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            txd     <= txd_d;
        end
    end

    // Completion interrupt, one cycle behind the idle-and-drained condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & empty & ~busy;
        end
    end

    // Register read mux; deselected reads return zero for the core's din mux.
    always_comb begin
        dout = 8'h00;
        if (sel) begin
            case (a)
                2'd1:    dout = {4'b0000, overrun, empty, full, busy};
                2'd2:    dout = {6'b000000, irq_en, tx_en};
                default: dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_m6809_uart_tx.sv
module tb_m6809_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic [1:0] a;
    logic       wr_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       txd;
    logic       irq;

    int checks = 0;
    int errors = 0;

    m6809_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .reset(reset),
        .sel  (sel),
        .a    (a),
        .wr_n (wr_n),
        .din  (din),
        .dout (dout),
        .txd  (txd),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: byte queue + frame position ----------------
    logic [7:0] mq[$];
    bit         m_valid = 0;
    bit         m_ovr, m_txen, m_irqen, m_act, m_irq;
    int         m_p;
    logic [7:0] m_cur;

    always @(posedge clk) begin : model_p
        bit pre_empty, pre_full, do_pop, wr, irq_next;
        pre_empty = (mq.size() == 0);
        pre_full  = (mq.size() == DEPTH);
        wr        = sel && !wr_n;
        if (reset) begin
            mq.delete();
            m_ovr = 0; m_txen = 1; m_irqen = 0; m_act = 0; m_p = 0; m_irq = 0;
            m_valid = 1;
        end else if (m_valid) begin
            irq_next = m_irqen && pre_empty && !m_act;
            do_pop   = !m_act && m_txen && !pre_empty;
            if (do_pop) begin
                m_cur = mq.pop_front();
                m_act = 1;
                m_p   = 0;
            end else if (m_act) begin
                m_p++;
                if (m_p == FRAME) m_act = 0;
            end
            if (wr && a == 2'd0) begin
                if (pre_full && !do_pop) m_ovr = 1;
                else mq.push_back(din);
            end
            if (wr && a == 2'd1 && din[3]) m_ovr = 0;
            if (wr && a == 2'd2) begin
                m_txen  = din[0];
                m_irqen = din[1];
            end
            m_irq = irq_next;
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_act) return 1'b1;
        k = m_p / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_dout();
        logic e, f;
        e = (mq.size() == 0);
        f = (mq.size() == DEPTH);
        if (!sel) return 8'h00;
        case (a)
            2'd1:    return {4'b0000, m_ovr, e, f, m_act};
            2'd2:    return {6'b000000, m_irqen, m_txen};
            default: return 8'h00;
        endcase
    endfunction

    // Per-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("model_txd", txd, exp_txd());
            check("model_irq", irq, m_irq);
            check("model_dout", dout, exp_dout());
        end
    end

    // ---------------- independent line receiver ----------------
    int         cyc = 0;
    bit         rx_act = 0;
    int         rx_cnt, rx_start;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (txd === 1'b0) begin
                rx_act = 1; rx_cnt = 0; rx_start = cyc; rx_byte = 8'h00;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= CPB && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                rx_byte[rx_cnt / CPB - 1] = txd;
            if (rx_cnt == FRAME - 1) begin
                rx_act = 0;
                rx_q.push_back(rx_byte);
                rx_t.push_back(rx_start);
            end
        end
    end

    logic [7:0] exp_b [8];

    task automatic check_rx(input string name, input int n);
        check({name, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check({name, "_byte"}, rx_q[i], exp_b[i]);
        for (int i = 1; i < rx_t.size(); i++)
            check({name, "_gap"}, rx_t[i] - rx_t[i-1], FRAME + 1);
    endtask

    // ---------------- bus driver tasks ----------------
    task automatic wr_raw(input logic [1:0] ad, input logic [7:0] d);
        @(negedge clk);
        sel = 1; wr_n = 0; a = ad; din = d;
    endtask

    task automatic idle();
        @(negedge clk);
        sel = 0; wr_n = 1; a = 2'd0; din = 8'h00;
    endtask

    task automatic write(input logic [1:0] ad, input logic [7:0] d);
        wr_raw(ad, d);
        idle();
    endtask

    task automatic rd_check(input string name, input logic [1:0] ad, input logic [7:0] exp);
        @(negedge clk);
        sel = 1; wr_n = 1; a = ad;
        #1;
        check(name, dout, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] f;
        int zeros;
        reset = 1; sel = 0; wr_n = 1; a = 2'd0; din = 8'h00;
        repeat (3) @(negedge clk);
        reset = 0;
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);
        rd_check("rst_status", 2'd1, 8'h04);
        rd_check("rst_ctrl", 2'd2, 8'h01);

        // Single frame of 0xA5 with STATUS held on the read mux.
        f = {1'b1, 8'hA5, 1'b0};
        write(2'd0, 8'hA5);
        sel = 1; wr_n = 1; a = 2'd1;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk); #1;
            check("a5_txd", txd, f[(i-1)/CPB]);
            check("a5_status", dout, 8'h05);
        end
        @(posedge clk); #1;
        check("a5_end_txd", txd, 1'b1);
        check("a5_end_status", dout, 8'h04);
        idle();

        // Overrun with transmitter disabled, then drain.
        write(2'd2, 8'h00);
        for (int i = 1; i <= 5; i++) write(2'd0, 8'(i));
        rd_check("ovr_status", 2'd1, 8'h0A);
        write(2'd1, 8'h08);
        rd_check("ovr_clr_status", 2'd1, 8'h02);
        rx_q.delete(); rx_t.delete();
        write(2'd2, 8'h01);
        repeat (4 * (FRAME + 1) + 10) @(posedge clk);
        for (int i = 0; i < 4; i++) exp_b[i] = 8'(i + 1);
        check_rx("ovr_rx", 4);

        // Push into a full FIFO in the very cycle the serialiser pops.
        write(2'd2, 8'h00);
        for (int i = 0; i < 4; i++) write(2'd0, 8'(8'h10 + i));
        rx_q.delete(); rx_t.delete();
        wr_raw(2'd2, 8'h01);
        wr_raw(2'd0, 8'h77);
        idle();
        rd_check("fullpop_status", 2'd1, 8'h03);
        repeat (5 * (FRAME + 1) + 10) @(posedge clk);
        for (int i = 0; i < 4; i++) exp_b[i] = 8'(8'h10 + i);
        exp_b[4] = 8'h77;
        check_rx("fullpop_rx", 5);
        rd_check("fullpop_end_status", 2'd1, 8'h04);
        idle();

        // Completion interrupt.
        write(2'd2, 8'h03);
        write(2'd0, 8'h3C);
        repeat (20) @(posedge clk);
        #1 check("irq_mid", irq, 1'b0);
        repeat (21) @(posedge clk);
        #1 check("irq_at_idle", irq, 1'b0);
        @(posedge clk);
        #1 check("irq_after_idle", irq, 1'b1);
        write(2'd2, 8'h01);
        @(posedge clk);
        #1 check("irq_dropped", irq, 1'b0);

        // Reset in the middle of data bit 3 of 0xFF.
        rx_q.delete(); rx_t.delete();
        write(2'd0, 8'hFF);
        repeat (17) @(posedge clk);
        #1 check("rst_mid_bit3", txd, 1'b1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0; sel = 1; wr_n = 1; a = 2'd1;
        #1;
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_status", dout, 8'h04);
        idle();
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) zeros++;
        end
        check("rst_mid_quiet", zeros, 0);
        check("rst_mid_rx", rx_q.size(), 0);

        // Randomised bus traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 999) < 3);
            sel   = ($urandom_range(0, 99) < 40);
            wr_n  = 1'($urandom_range(0, 1));
            a     = 2'($urandom_range(0, 3));
            din   = 8'($urandom_range(0, 255));
            if (a == 2'd2) din[0] = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        reset = 0;
        idle();
        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
